jt08_wr_sched: RTL and testbench

//  Host-side write scheduler for the jt08 YM2608 core. Buffers CPU register writes
//  (port addr + data) in a FIFO and replays them to the jt08 host bus, enforcing
//  the chip's minimum post-write gaps. Lets the CPU write at full speed without

---
 rtl/jt08_wr_sched_pkg.sv | 11 +
 rtl/jt08_wr_fifo.sv | 40 ++++
 rtl/jt08_wr_sched.sv | 124 ++++++++++++
 tb/tb_jt08_wr_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt08_wr_sched_pkg.sv
// jt08_wr_sched_pkg: shared types and constants for the jt08 write scheduler
package jt08_wr_sched_pkg;
  typedef enum logic [1:0] {IDLE, WR, GAP, RD} state_t;
  localparam logic [7:0] FM_REG = 8'h21;
  localparam int ENT_W = 10;
  localparam int ENT_PORT = 8;
  localparam int ENT_BANK = 9;
  function automatic logic is_fm(input logic bank, input logic [7:0] r);
    return bank | (r >= FM_REG);
  endfunction
endpackage

// File: rtl/jt08_wr_fifo.sv
// jt08_wr_fifo: synchronous FIFO for queued host writes, push+pop legal when full or empty
module jt08_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  // storage, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/jt08_wr_sched.sv
// jt08_wr_sched: buffers host writes and replays them to jt08 with post-write gaps
module jt08_wr_sched
  import jt08_wr_sched_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_GAP    = 17,
  parameter int DATA_GAP_LO = 17,
  parameter int DATA_GAP_FM = 83
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       h_cs_n,
  input  logic       h_wr_n,
  input  logic       h_rd_n,
  input  logic [1:0] h_addr,
  input  logic [7:0] h_din,
  output logic [7:0] h_dout,
  output logic       h_wait,
  output logic       fifo_full,
  output logic       ovf,
  output logic       chip_cs_n,
  output logic       chip_wr_n,
  output logic       chip_rd_n,
  output logic [1:0] chip_addr,
  output logic [7:0] chip_din,
  input  logic [7:0] chip_dout
);
  localparam int MG0 = ADDR_GAP > DATA_GAP_LO ? ADDR_GAP : DATA_GAP_LO;
  localparam int MAX_GAP = MG0 > DATA_GAP_FM ? MG0 : DATA_GAP_FM;
  localparam int GW = $clog2(MAX_GAP) + 1;
  state_t state, state_n;
  logic wr_term, wr_term_d, push, pop, empty, rd_pend, rd_done, rd_cnt, is_addr, last_bank;
  logic [7:0] last_reg;
  logic [GW-1:0] gap, gap_ld;
  logic [ENT_W-1:0] head;
  assign wr_term = ~h_cs_n & ~h_wr_n;
  assign push = wr_term & ~wr_term_d;
  assign rd_pend = ~h_cs_n & ~h_rd_n;
  assign h_wait = rd_pend & ~rd_done;
  assign pop = (state == WR) & cen;
  assign is_addr = ~head[ENT_PORT];
  assign gap_ld = is_addr ? GW'(ADDR_GAP) : is_fm(last_bank, last_reg) ? GW'(DATA_GAP_FM) : GW'(DATA_GAP_LO);
  jt08_wr_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({h_addr, h_din}),
    .dout(head),
    .full(fifo_full),
    .empty(empty)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state: queued writes win over a pending read
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !empty ? WR : rd_pend ? RD : IDLE;
      WR:   state_n = !cen ? WR : gap_ld == '0 ? IDLE : GAP;
      GAP:  state_n = (gap == '0 || (cen && gap == GW'(1))) ? IDLE : GAP;
      RD:   state_n = (rd_done && !rd_pend) ? IDLE : RD;
    endcase
  end
  // chip bus, gap counter, register tracking and read capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_term_d <= 1'b0;
      ovf <= 1'b0;
      chip_cs_n <= 1'b1;
      chip_wr_n <= 1'b1;
      chip_rd_n <= 1'b1;
      chip_addr <= '0;
      chip_din <= '0;
      h_dout <= '0;
      gap <= '0;
      last_reg <= '0;
      last_bank <= 1'b0;
      rd_cnt <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      wr_term_d <= wr_term;
      ovf <= ovf | (push & fifo_full & ~pop);
      case (state)
        IDLE:
          if (!empty) begin
            chip_cs_n <= 1'b0;
            chip_wr_n <= 1'b0;
            chip_addr <= head[ENT_BANK:ENT_PORT];
            chip_din <= head[7:0];
          end else if (rd_pend) begin
            chip_cs_n <= 1'b0;
            chip_rd_n <= 1'b0;
            chip_addr <= h_addr;
            rd_cnt <= 1'b0;
          end
        WR:
          if (cen) begin
            chip_cs_n <= 1'b1;
            chip_wr_n <= 1'b1;
            gap <= gap_ld;
            if (is_addr) begin
              last_reg <= head[7:0];
              last_bank <= head[ENT_BANK];
            end
          end
        GAP:
          if (cen && gap != '0) gap <= gap - 1'b1;
        RD:
          if (!rd_done) begin
            rd_cnt <= 1'b1;
            if (rd_cnt) begin
              h_dout <= chip_dout;
              rd_done <= 1'b1;
              chip_cs_n <= 1'b1;
              chip_rd_n <= 1'b1;
            end
          end else if (!rd_pend) rd_done <= 1'b0;
      endcase
    end
endmodule

// File: tb/tb_jt08_wr_sched.sv
// tb_jt08_wr_sched: randomized scenarios checked against a gap/order reference model
module tb_jt08_wr_sched;
  logic clk = 0, rst_n = 0, cen = 0, h_cs_n = 1, h_wr_n = 1, h_rd_n = 1;
  logic [1:0] h_addr = 0;
  logic [7:0] h_din = 0, chip_dout = 8'h80;
  logic [7:0] h_dout, chip_din;
  logic h_wait, fifo_full, ovf, chip_cs_n, chip_wr_n, chip_rd_n;
  logic [1:0] chip_addr;
  int total = 0, bad = 0, cen_mode = 0, cyc = 0, cen_cnt = 0, rd_clks = 0, rd_gap = -1;
  logic cen_req = 0, rd_prev = 1;
  logic [9:0] obs_q[$];
  int gap_q[$];
  logic [7:0] m_reg = 0;
  logic m_bank = 0;

  jt08_wr_sched dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .h_cs_n(h_cs_n), .h_wr_n(h_wr_n), .h_rd_n(h_rd_n),
    .h_addr(h_addr), .h_din(h_din), .h_dout(h_dout), .h_wait(h_wait), .fifo_full(fifo_full),
    .ovf(ovf), .chip_cs_n(chip_cs_n), .chip_wr_n(chip_wr_n), .chip_rd_n(chip_rd_n),
    .chip_addr(chip_addr), .chip_din(chip_din), .chip_dout(chip_dout)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    cen = cen_mode == 1 ? (cyc % 4 == 0) : cen_mode == 2 ? ($urandom_range(0, 2) == 0) : cen_req;
  end

  always @(posedge clk) begin
    if (!chip_cs_n && !chip_wr_n && cen) begin
      obs_q.push_back({chip_addr, chip_din});
      gap_q.push_back(cen_cnt);
      cen_cnt <= 0;
    end else if (cen && chip_wr_n) cen_cnt <= cen_cnt + 1;
    if (!chip_cs_n && !chip_rd_n) begin
      if (rd_prev) rd_gap <= cen_cnt;
      rd_clks <= rd_clks + 1;
    end
    rd_prev <= chip_rd_n;
  end

  task automatic model_gap(input logic [9:0] e, output int g);
    if (!e[8]) begin
      g = 17;
      m_reg = e[7:0];
      m_bank = e[9];
    end else g = (m_bank || m_reg >= 8'h21) ? 83 : 17;
  endtask

  task automatic push_wr(input logic [9:0] e);
    @(negedge clk);
    h_addr = e[9:8];
    h_din = e[7:0];
    h_cs_n = 0;
    h_wr_n = 0;
    @(negedge clk);
    h_cs_n = 1;
    h_wr_n = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cen_mode = 0;
    cen_req = 0;
    h_cs_n = 1;
    h_wr_n = 1;
    h_rd_n = 1;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m_reg = 0;
    m_bank = 0;
  endtask

  task automatic test_reset();
    int b;
    repeat (2) @(negedge clk);
    rst_n = 1;
    total++;
    if ({chip_cs_n, chip_wr_n, chip_rd_n} !== 3'b111) begin
      bad++; $display("FAIL reset_strobes got=%b want=111", {chip_cs_n, chip_wr_n, chip_rd_n});
    end
    total++;
    if ({chip_addr, chip_din, h_dout} !== 18'h0) begin
      bad++; $display("FAIL reset_bus got=%h want=0", {chip_addr, chip_din, h_dout});
    end
    total++;
    if ({h_wait, ovf, fifo_full} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {h_wait, ovf, fifo_full});
    end
    push_wr(10'h028);
    push_wr(10'h1F0);
    total++;
    if ({chip_cs_n, chip_wr_n} !== 2'b00) begin
      bad++; $display("FAIL reset_pre_wr got=%b want=00", {chip_cs_n, chip_wr_n});
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({chip_cs_n, chip_wr_n} !== 2'b11) begin
      bad++; $display("FAIL reset_async_strobe got=%b want=11", {chip_cs_n, chip_wr_n});
    end
    total++;
    if ({fifo_full, ovf} !== 2'b00) begin
      bad++; $display("FAIL reset_async_flags got=%b want=00", {fifo_full, ovf});
    end
    @(negedge clk);
    rst_n = 1;
    m_reg = 0;
    m_bank = 0;
    b = obs_q.size();
    cen_mode = 1;
    repeat (300) @(negedge clk);
    total++;
    if (obs_q.size() != b) begin
      bad++; $display("FAIL reset_flush got=%0d writes want=0", obs_q.size() - b);
    end
  endtask

  task automatic test_gaps();
    logic [9:0] tab [7] = '{10'h028, 10'h1F0, 10'h007, 10'h138, 10'h210, 10'h355, 10'h000};
    int g [7];
    int b = obs_q.size();
    cen_mode = 1;
    foreach (tab[i]) push_wr(tab[i]);
    foreach (tab[i]) model_gap(tab[i], g[i]);
    for (int k = 0; k < 6000 && obs_q.size() < b + 7; k++) @(negedge clk);
    total++;
    if (obs_q.size() != b + 7) begin
      bad++; $display("FAIL gaps_count got=%0d want=7", obs_q.size() - b);
    end
    for (int i = 0; i < 7 && b + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[b+i] !== tab[i]) begin
        bad++; $display("FAIL gaps_order[%0d] got=%h want=%h", i, obs_q[b+i], tab[i]);
      end
      if (i > 0) begin
        total++;
        if (gap_q[b+i] != g[i-1]) begin
          bad++; $display("FAIL gaps_len[%0d] got=%0d want=%0d", i, gap_q[b+i], g[i-1]);
        end
      end
    end
  endtask

  task automatic test_read();
    logic [9:0] e [3];
    logic [9:0] late;
    int g [4];
    int b = obs_q.size();
    int rb = rd_clks;
    cen_mode = 1;
    chip_dout = 8'h80 | 8'($urandom_range(0, 127));
    e[0] = {2'b00, 8'($urandom_range(0, 255))};
    e[1] = {2'b01, 8'($urandom_range(0, 255))};
    e[2] = {2'b00, 8'($urandom_range(0, 255))};
    foreach (e[i]) push_wr(e[i]);
    foreach (e[i]) model_gap(e[i], g[i]);
    @(negedge clk);
    h_addr = 2'b00;
    h_cs_n = 0;
    h_rd_n = 0;
    @(negedge clk);
    total++;
    if (h_wait !== 1'b1) begin
      bad++; $display("FAIL rd_wait_hi got=%b want=1", h_wait);
    end
    for (int k = 0; k < 5000 && h_wait; k++) @(negedge clk);
    total++;
    if (obs_q.size() != b + 3) begin
      bad++; $display("FAIL rd_drained got=%0d want=3", obs_q.size() - b);
    end
    total++;
    if (rd_gap != g[2]) begin
      bad++; $display("FAIL rd_after_gap got=%0d want=%0d", rd_gap, g[2]);
    end
    total++;
    if (h_dout !== chip_dout) begin
      bad++; $display("FAIL rd_data got=%h want=%h", h_dout, chip_dout);
    end
    total++;
    if (rd_clks - rb != 2) begin
      bad++; $display("FAIL rd_len got=%0d want=2", rd_clks - rb);
    end
    late = {2'b01, 8'($urandom_range(0, 255))};
    h_din = late[7:0];
    h_addr = late[9:8];
    h_wr_n = 0;
    @(negedge clk);
    h_wr_n = 1;
    repeat (100) @(negedge clk);
    total++;
    if (obs_q.size() != b + 3) begin
      bad++; $display("FAIL rd_hold_wr got=%0d want=3", obs_q.size() - b);
    end
    h_rd_n = 1;
    h_cs_n = 1;
    @(negedge clk);
    total++;
    if (h_wait !== 1'b0) begin
      bad++; $display("FAIL rd_wait_lo got=%b want=0", h_wait);
    end
    model_gap(late, g[3]);
    for (int k = 0; k < 2000 && obs_q.size() < b + 4; k++) @(negedge clk);
    total++;
    if (obs_q.size() != b + 4) begin
      bad++; $display("FAIL rd_late_wr got=%0d writes want=4", obs_q.size() - b);
    end else if (obs_q[b+3] !== late) begin
      bad++; $display("FAIL rd_late_wr got=%h want=%h", obs_q[b+3], late);
    end
  endtask

  task automatic test_hold_full();
    logic [9:0] e [17];
    int b;
    do_reset();
    b = obs_q.size();
    foreach (e[i]) e[i] = {1'($urandom_range(0, 1)), 1'b0, 8'($urandom_range(0, 255))};
    @(negedge clk);
    h_addr = e[0][9:8];
    h_din = e[0][7:0];
    h_cs_n = 0;
    h_wr_n = 0;
    repeat (50) @(negedge clk);
    h_cs_n = 1;
    h_wr_n = 1;
    for (int i = 1; i < 16; i++) push_wr(e[i]);
    total++;
    if ({fifo_full, ovf} !== 2'b10) begin
      bad++; $display("FAIL hold_fill got=%b want=10", {fifo_full, ovf});
    end
    @(negedge clk);
    h_addr = e[16][9:8];
    h_din = e[16][7:0];
    h_cs_n = 0;
    h_wr_n = 0;
    cen_req = 1;
    @(negedge clk);
    h_cs_n = 1;
    h_wr_n = 1;
    cen_req = 0;
    @(negedge clk);
    total++;
    if ({fifo_full, ovf} !== 2'b10) begin
      bad++; $display("FAIL full_push_pop got=%b want=10", {fifo_full, ovf});
    end
    cen_mode = 1;
    for (int k = 0; k < 6000 && obs_q.size() < b + 17; k++) @(negedge clk);
    repeat (300) @(negedge clk);
    total++;
    if (obs_q.size() != b + 17) begin
      bad++; $display("FAIL hold_count got=%0d want=17", obs_q.size() - b);
    end
    for (int i = 0; i < 17 && b + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[b+i] !== e[i]) begin
        bad++; $display("FAIL hold_order[%0d] got=%h want=%h", i, obs_q[b+i], e[i]);
      end
    end
    foreach (e[i]) begin
      int g;
      model_gap(e[i], g);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] e [17];
    int g [16];
    int b = obs_q.size();
    cen_mode = 0;
    cen_req = 0;
    @(negedge clk);
    foreach (e[i]) e[i] = 10'($urandom);
    foreach (e[i]) push_wr(e[i]);
    total++;
    if (fifo_full !== 1'b1) begin
      bad++; $display("FAIL ovf_full got=%b want=1", fifo_full);
    end
    total++;
    if (ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_flag got=%b want=1", ovf);
    end
    foreach (g[i]) model_gap(e[i], g[i]);
    cen_mode = 1;
    for (int k = 0; k < 9000 && obs_q.size() < b + 16; k++) @(negedge clk);
    repeat (600) @(negedge clk);
    total++;
    if (obs_q.size() != b + 16) begin
      bad++; $display("FAIL ovf_count got=%0d want=16", obs_q.size() - b);
    end
    for (int i = 0; i < 16 && b + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[b+i] !== e[i]) begin
        bad++; $display("FAIL ovf_order[%0d] got=%h want=%h", i, obs_q[b+i], e[i]);
      end
      if (i > 0) begin
        total++;
        if (gap_q[b+i] != g[i-1]) begin
          bad++; $display("FAIL ovf_gap[%0d] got=%0d want=%0d", i, gap_q[b+i], g[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] e [10];
    int g [10];
    int b = obs_q.size();
    cen_mode = 2;
    foreach (e[i]) e[i] = 10'($urandom);
    foreach (e[i]) push_wr(e[i]);
    foreach (e[i]) model_gap(e[i], g[i]);
    for (int k = 0; k < 9000 && obs_q.size() < b + 10; k++) @(negedge clk);
    total++;
    if (obs_q.size() != b + 10) begin
      bad++; $display("FAIL rnd_count got=%0d want=10", obs_q.size() - b);
    end
    for (int i = 0; i < 10 && b + i < obs_q.size(); i++) begin
      total++;
      if (obs_q[b+i] !== e[i]) begin
        bad++; $display("FAIL rnd_order[%0d] got=%h want=%h", i, obs_q[b+i], e[i]);
      end
      if (i > 0) begin
        total++;
        if (gap_q[b+i] < g[i-1] || gap_q[b+i] > g[i-1] + 1) begin
          bad++; $display("FAIL rnd_gap[%0d] got=%0d want=%0d..%0d", i, gap_q[b+i], g[i-1], g[i-1] + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_gaps();
    test_read();
    test_hold_full();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
